// File: rtl/inst_queue_pkg.sv
// Shared types for the instruction queue: the stored entry layout and its default depth.
package inst_queue_pkg;

  localparam int INST_QUEUE_DEPTH = 16;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic            pre_is_branch;
    logic            pre_is_branch_taken;
    logic [31:0]     pre_branch_addr;
    logic [5:0]      is_exception;
    logic [5:0][6:0] exception_cause;
  } inst_queue_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Dual-width circular instruction queue between fetch and decode, presenting the
// two oldest entries first-word-fall-through and retiring them on send_inst_en.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH         = INST_QUEUE_DEPTH,
  parameter int DECODER_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [DECODER_WIDTH-1:0]            fetch_valid,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_pc,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_inst,
  input  logic [DECODER_WIDTH-1:0]            fetch_pre_is_branch,
  input  logic [DECODER_WIDTH-1:0]            fetch_pre_is_branch_taken,
  input  logic [DECODER_WIDTH-1:0][31:0]      fetch_pre_branch_addr,
  input  logic [DECODER_WIDTH-1:0][5:0]       fetch_is_exception,
  input  logic [DECODER_WIDTH-1:0][5:0][6:0]  fetch_exception_cause,
  output logic                                full,
  input  logic [DECODER_WIDTH-1:0]            send_inst_en,
  output logic [DECODER_WIDTH-1:0]            inst_valid,
  output logic [DECODER_WIDTH-1:0][31:0]      pc,
  output logic [DECODER_WIDTH-1:0][31:0]      inst,
  output logic [DECODER_WIDTH-1:0]            pre_is_branch,
  output logic [DECODER_WIDTH-1:0]            pre_is_branch_taken,
  output logic [DECODER_WIDTH-1:0][31:0]      pre_branch_addr,
  output logic [DECODER_WIDTH-1:0][5:0]       is_exception,
  output logic [DECODER_WIDTH-1:0][5:0][6:0]  exception_cause,
  output logic                                pause_buffer
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  inst_queue_entry_t mem [DEPTH];

  inst_queue_entry_t in_entry [DECODER_WIDTH];
  inst_queue_entry_t slot     [DECODER_WIDTH];
  logic              push_en;
  logic [PW:0]       push_n;
  logic [PW:0]       pop_n;
  logic [DECODER_WIDTH-1:0] take;

  // Handshake: fetch slot i transfers when fetch_valid[i] && !full; decode slot i
  // transfers when inst_valid[i] && send_inst_en[i] and every lower slot transfers too.
  assign full         = (count >= (PW+1)'(DEPTH - 1));
  assign inst_valid   = {count >= (PW+1)'(2), count != '0};
  assign pause_buffer = ~inst_valid[0];

  assign push_en = ~full & ~flush & ~rst;
  assign take    = send_inst_en & inst_valid;
  assign push_n  = push_en ? ((PW+1)'(fetch_valid[0]) + (PW+1)'(fetch_valid[1])) : '0;
  assign pop_n   = take[0] ? (take[1] ? (PW+1)'(2) : (PW+1)'(1)) : '0;

  always_comb begin
    for (int i = 0; i < DECODER_WIDTH; i++) begin
      in_entry[i] = '{pc:                  fetch_pc[i],
                      inst:                fetch_inst[i],
                      pre_is_branch:       fetch_pre_is_branch[i],
                      pre_is_branch_taken: fetch_pre_is_branch_taken[i],
                      pre_branch_addr:     fetch_pre_branch_addr[i],
                      is_exception:        fetch_is_exception[i],
                      exception_cause:     fetch_exception_cause[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_n[PW-1:0];
      tail  <= tail + push_n[PW-1:0];
      count <= count + push_n - pop_n;
    end
  end

  // Slot 1 lands right behind slot 0 only when slot 0 was valid; otherwise it takes the tail.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (fetch_valid[0]) mem[tail] <= in_entry[0];
      if (fetch_valid[1]) mem[tail + PW'(fetch_valid[0])] <= in_entry[1];
    end
  end

  always_comb begin
    slot[0] = mem[head];
    slot[1] = mem[head + PW'(1)];
    for (int i = 0; i < DECODER_WIDTH; i++) begin
      if (!inst_valid[i]) slot[i] = '0;
      pc[i]                  = slot[i].pc;
      inst[i]                = slot[i].inst;
      pre_is_branch[i]       = slot[i].pre_is_branch;
      pre_is_branch_taken[i] = slot[i].pre_is_branch_taken;
      pre_branch_addr[i]     = slot[i].pre_branch_addr;
      is_exception[i]        = slot[i].is_exception;
      exception_cause[i]     = slot[i].exception_cause;
    end
  end

endmodule
